// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM arbiter: requester enum,
// slot phase markers and the default refresh spacing.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    LDR  = 2'd1,
    CPU  = 2'd2,
    VID  = 2'd3
  } port_e;

  localparam logic [2:0] PH_DECIDE       = 3'd7;
  localparam logic [2:0] PH_IDLE         = 3'd0;
  localparam int         REFRESH_MAX_DEF = 16;

endpackage

// File: rtl/sdram_phase_gen.sv
// Eight-phase counter for the SDRAM controller, phase-locked to clkref,
// plus a sticky lock flag and a one-cycle slot-boundary strobe.
module sdram_phase_gen
  import sdram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clkref,
  output logic [2:0] q,
  output logic       locked,
  output logic       slot_edge
);

  logic [2:0] q_next;

  // q parks at 7 waiting for clkref and at 0 until clkref falls again.
  always_comb begin
    q_next = q + 3'd1;
    if ((q == PH_DECIDE) && !clkref) q_next = q;
    if ((q == PH_IDLE) && clkref)    q_next = q;
  end

  assign slot_edge = (q == PH_DECIDE) && clkref;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q      <= 3'd0;
      locked <= 1'b0;
    end else begin
      q <= q_next;
      if ((q == PH_IDLE) && (q_next == 3'd1)) locked <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller between loader, CPU and video: one grant per
// 8-phase slot, read capture with a one-cycle ack, forced refresh slots.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter logic [2:0] READ_PHASE  = 3'd6,
  parameter int         REFRESH_MAX = REFRESH_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clkref,
  output logic [2:0]  q,
  output logic [24:0] ctl_addr,
  output logic [7:0]  ctl_din,
  output logic        ctl_oe,
  output logic        ctl_we,
  input  logic [7:0]  ctl_dout,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [24:0] ldr_addr,
  input  logic [7:0]  ldr_din,
  output logic        ldr_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dout,
  input  logic        vid_req,
  input  logic [24:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_dout
);

  localparam int RW = $clog2(REFRESH_MAX + 1);
  localparam logic [RW-1:0] REF_LIMIT = RW'(REFRESH_MAX);

  logic          locked;
  logic          slot_edge;
  port_e         grant;
  port_e         pick;
  port_e         rr;
  logic [RW-1:0] refresh_cnt;
  logic          ldr_ok, cpu_ok, vid_ok;

  sdram_phase_gen u_phase (
    .clk       (clk),
    .reset_n   (reset_n),
    .clkref    (clkref),
    .q         (q),
    .locked    (locked),
    .slot_edge (slot_edge)
  );

  // A port whose ack is still high has just been served and sits this slot out.
  always_comb begin
    ldr_ok = ldr_req && !ldr_ack;
    cpu_ok = cpu_req && !cpu_ack;
    vid_ok = vid_req && !vid_ack;
    pick   = NONE;
    if (locked && (refresh_cnt != REF_LIMIT)) begin
      if (ldr_ok)                      pick = LDR;
      else if (rr == CPU && cpu_ok)    pick = CPU;
      else if (vid_ok)                 pick = VID;
      else if (cpu_ok)                 pick = CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant       <= NONE;
      rr          <= CPU;
      refresh_cnt <= '0;
      ctl_addr    <= 25'd0;
      ctl_din     <= 8'd0;
      ctl_oe      <= 1'b0;
      ctl_we      <= 1'b0;
      ldr_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      vid_ack     <= 1'b0;
      cpu_dout    <= 8'd0;
      vid_dout    <= 8'd0;
    end else begin
      ldr_ack <= 1'b0;
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;

      if (slot_edge) begin
        grant <= pick;
        case (pick)
          LDR: begin
            ctl_addr <= ldr_addr;
            ctl_din  <= ldr_din;
            ctl_we   <= ldr_we;
            ctl_oe   <= !ldr_we;
          end
          CPU: begin
            ctl_addr <= cpu_addr;
            ctl_din  <= cpu_din;
            ctl_we   <= cpu_we;
            ctl_oe   <= !cpu_we;
          end
          VID: begin
            ctl_addr <= vid_addr;
            ctl_din  <= 8'd0;
            ctl_we   <= 1'b0;
            ctl_oe   <= 1'b1;
          end
          default: begin
            ctl_addr <= 25'd0;
            ctl_din  <= 8'd0;
            ctl_we   <= 1'b0;
            ctl_oe   <= 1'b0;
          end
        endcase

        if (pick == NONE)                 refresh_cnt <= '0;
        else if (refresh_cnt != REF_LIMIT) refresh_cnt <= refresh_cnt + RW'(1);

        if (pick == CPU)      rr <= VID;
        else if (pick == VID) rr <= CPU;
      end

      if (q == READ_PHASE) begin
        case (grant)
          LDR: ldr_ack <= 1'b1;
          CPU: begin
            cpu_ack <= 1'b1;
            if (!ctl_we) cpu_dout <= ctl_dout;
          end
          VID: begin
            vid_ack  <= 1'b1;
            vid_dout <= ctl_dout;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench: slot-level reference model of the arbitration rules
// driven with random and directed requester traffic.
module tb_sdram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clkref;
   logic [2:0]  q;
   logic [24:0] ctl_addr;
   logic [7:0]  ctl_din;
   logic        ctl_oe, ctl_we;
   logic [7:0]  ctl_dout;
   logic        ldr_req, ldr_we, ldr_ack;
   logic [24:0] ldr_addr;
   logic [7:0]  ldr_din;
   logic        cpu_req, cpu_we, cpu_ack;
   logic [24:0] cpu_addr;
   logic [7:0]  cpu_din, cpu_dout;
   logic        vid_req, vid_ack;
   logic [24:0] vid_addr;
   logic [7:0]  vid_dout;

   sdram_arbiter dut (
      .clk(clk), .reset_n(reset_n), .clkref(clkref), .q(q),
      .ctl_addr(ctl_addr), .ctl_din(ctl_din), .ctl_oe(ctl_oe), .ctl_we(ctl_we),
      .ctl_dout(ctl_dout),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_din(ldr_din),
      .ldr_ack(ldr_ack),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int off;

   // Ports indexed 1=loader, 2=CPU, 3=video; 0 means no grant.
   bit          mreq[4];
   bit          mwe[4];
   logic [24:0] maddr[4];
   logic [7:0]  mdin[4];
   int          pg, rcnt, rr, g;
   bit          g_we, g_oe;
   logic [24:0] g_addr;
   logic [7:0]  g_din;
   logic [7:0]  m_cpu_dout, m_vid_dout, slot_dout;
   int          ngrant[4];
   bit          dir_pending;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      clkref = ((cyc % 8) == off);
   endtask

   task automatic wait_clkref();
      int b = 0;
      while (!clkref && b < 16) begin
         step();
         b++;
      end
   endtask

   task automatic drive_ports();
      ldr_req = mreq[1]; ldr_we = mwe[1]; ldr_addr = maddr[1]; ldr_din = mdin[1];
      cpu_req = mreq[2]; cpu_we = mwe[2]; cpu_addr = maddr[2]; cpu_din = mdin[2];
      vid_req = mreq[3]; vid_addr = maddr[3];
   endtask

   task automatic model_reset();
      pg = 0; rcnt = 0; rr = 2; g = 0;
      g_we = 0; g_oe = 0; g_addr = '0; g_din = '0;
      m_cpu_dout = 8'd0; m_vid_dout = 8'd0;
      for (int p = 0; p < 4; p++) begin
         mreq[p] = 0; mwe[p] = 0; maddr[p] = '0; mdin[p] = '0;
      end
   endtask

   // mode 0 random, 1 all saturate, 2 loader fixed writes, 3 directed CPU read,
   // 4 drain, 5 CPU+video only
   task automatic new_req(int p, int mode);
      mwe[p]   = (p == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      maddr[p] = 25'($urandom);
      mdin[p]  = 8'($urandom);
      case (mode)
         0: mreq[p] = 1'($urandom_range(0, 1));
         1: mreq[p] = 1'b1;
         2: begin
            mreq[p] = 1'b1;
            if (p == 1) begin
               mwe[p] = 1'b1; maddr[p] = 25'h0100000; mdin[p] = 8'h5A;
            end
         end
         3: begin
            mreq[p] = 1'b0;
            if (p == 2 && dir_pending) begin
               mreq[p] = 1'b1; mwe[p] = 1'b0; maddr[p] = 25'h0001234;
               dir_pending = 0;
            end
         end
         5: mreq[p] = (p != 1);
         default: mreq[p] = 1'b0;
      endcase
   endtask

   task automatic run_slots(int n, int mode);
      bit el[4];
      for (int s = 0; s < n; s++) begin
         // Cycle with q==7: previous slot still held, its ack visible.
         chk("q_at_decide", q, 3'd7);
         chk("oe_hold", ctl_oe, g_oe);
         chk("we_hold", ctl_we, g_we);
         chk("addr_hold", ctl_addr, g_addr);
         chk("din_hold", ctl_din, g_din);
         chk("ldr_ack", ldr_ack, (pg == 1));
         chk("cpu_ack", cpu_ack, (pg == 2));
         chk("vid_ack", vid_ack, (pg == 3));
         if (pg == 2 && !g_we) m_cpu_dout = slot_dout;
         if (pg == 3)          m_vid_dout = slot_dout;
         chk("cpu_dout", cpu_dout, m_cpu_dout);
         chk("vid_dout", vid_dout, m_vid_dout);

         for (int p = 1; p < 4; p++)
            if (!mreq[p] || pg == p) new_req(p, mode);
         drive_ports();

         for (int p = 1; p < 4; p++) el[p] = mreq[p] && (pg != p);
         el[0] = 0;
         if (rcnt == 16)   g = 0;
         else if (el[1])   g = 1;
         else if (rr == 2) g = el[2] ? 2 : (el[3] ? 3 : 0);
         else              g = el[3] ? 3 : (el[2] ? 2 : 0);
         if (g == 2) rr = 3;
         else if (g == 3) rr = 2;
         rcnt   = (g == 0) ? 0 : ((rcnt < 16) ? rcnt + 1 : 16);
         g_we   = (g == 0) ? 1'b0 : mwe[g];
         g_oe   = (g != 0) && !g_we;
         g_addr = (g == 0) ? 25'd0 : maddr[g];
         g_din  = (g == 1 || g == 2) ? mdin[g] : 8'd0;
         ngrant[g]++;

         step();
         slot_dout = (mode == 3) ? 8'hA5 : 8'($urandom);
         ctl_dout  = slot_dout;
         chk("q_slot_start", q, 3'd0);
         for (int k = 1; k <= 7; k++) begin
            chk("ctl_oe", ctl_oe, g_oe);
            chk("ctl_we", ctl_we, g_we);
            chk("ctl_addr", ctl_addr, g_addr);
            chk("ctl_din", ctl_din, g_din);
            chk("ack_quiet", {ldr_ack, cpu_ack, vid_ack}, 3'b000);
            if (k < 7) step();
         end
         step();
         pg = g;
      end
   endtask

   initial begin
      off = $urandom_range(0, 7);
      reset_n = 1'b0;
      clkref = 1'b0;
      ctl_dout = 8'd0;
      dir_pending = 0;
      model_reset();
      drive_ports();
      repeat (3) step();

      chk("rst_q", q, 3'd0);
      chk("rst_ctl", {ctl_oe, ctl_we}, 2'b00);
      chk("rst_addr", ctl_addr, 25'd0);
      chk("rst_din", ctl_din, 8'd0);
      chk("rst_acks", {ldr_ack, cpu_ack, vid_ack}, 3'b000);
      chk("rst_douts", {cpu_dout, vid_dout}, 16'd0);

      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("prelock_ctl", {ctl_oe, ctl_we}, 2'b00);
      end
      wait_clkref();
      chk("clkref_found", clkref, 1'b1);

      // CPU and video alternate, starting with CPU.
      for (int p = 0; p < 4; p++) ngrant[p] = 0;
      run_slots(8, 5);
      chk("alt_cpu_count", ngrant[2], 4);
      chk("alt_vid_count", ngrant[3], 4);

      run_slots(40, 0);

      for (int p = 0; p < 4; p++) ngrant[p] = 0;
      run_slots(40, 1);
      chk("saturate_refresh_seen", (ngrant[0] >= 2), 1'b1);

      for (int p = 0; p < 4; p++) ngrant[p] = 0;
      run_slots(12, 2);
      chk("ldr_grants", (ngrant[1] >= 5), 1'b1);

      run_slots(6, 4);
      dir_pending = 1;
      for (int p = 0; p < 4; p++) ngrant[p] = 0;
      run_slots(3, 3);
      chk("single_read_grants", ngrant[2], 1);
      chk("single_read_dout", cpu_dout, 8'hA5);

      // Reset in the middle of a CPU read slot.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0ABCDE;
      ldr_req = 1'b0; vid_req = 1'b0;
      step();
      chk("midrst_oe", ctl_oe, 1'b1);
      chk("midrst_addr", ctl_addr, 25'h0ABCDE);
      repeat (3) step();
      chk("midrst_phase", q, 3'd3);
      reset_n = 1'b0;
      step();
      chk("midrst_q", q, 3'd0);
      chk("midrst_ctl", {ctl_oe, ctl_we}, 2'b00);
      chk("midrst_addr0", ctl_addr, 25'd0);
      chk("midrst_din0", ctl_din, 8'd0);
      chk("midrst_acks", {ldr_ack, cpu_ack, vid_ack}, 3'b000);
      chk("midrst_douts", {cpu_dout, vid_dout}, 16'd0);
      reset_n = 1'b1;
      model_reset();
      drive_ports();
      for (int i = 0; i < 24; i++) begin
         step();
         chk("postrst_no_ack", {ldr_ack, cpu_ack, vid_ack}, 3'b000);
      end
      wait_clkref();
      chk("clkref_found_post", clkref, 1'b1);
      run_slots(10, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
